// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - fetch unit bundle: instruction memory, decode, redirect/halt.
interface instr_fetch_unit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          imem_req;
  logic [15:0]   imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_data;
  logic          inst_valid;
  logic [15:0]   inst;
  logic [15:0]   inst_pc;
  logic          inst_ready;
  logic          redirect;
  logic [15:0]   redirect_pc;
  logic          halt;
  logic          halted;
  logic [CW-1:0] count;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, halted, count,
    input  imem_ack, imem_data, inst_ready, redirect, redirect_pc, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, halted, count,
    output imem_ack, imem_data, inst_ready, redirect, redirect_pc, halt
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, single-outstanding imem reads, PC-tagged instruction FIFO.
module instr_fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, REQ, DRAIN, DRAIN_HALT, HALTED} state_t;

  state_t        state, state_next;
  logic [15:0]   fpc, fpc_next, addr_q, target;
  logic [15:0]   fifo_inst [DEPTH];
  logic [15:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt, cnt_next;
  logic          push, pop, flush, valid, ack, room;

  assign ack    = bus.imem_ack;
  assign target = bus.redirect_pc & 16'hFFFE;
  assign valid  = (cnt != '0);
  assign pop    = valid & bus.inst_ready;

  always_comb begin
    flush      = 1'b0;
    push       = 1'b0;
    state_next = state;
    fpc_next   = fpc;

    // halt and redirect both empty the queue; redirect in a halt drain is ignored
    if (state != HALTED) begin
      if (bus.halt) flush = 1'b1;
      else if (bus.redirect && state != DRAIN_HALT) flush = 1'b1;
    end
    push     = (state == REQ) && ack && !flush;
    cnt_next = flush ? '0 : cnt + CW'(push) - CW'(pop);
    room     = (cnt_next < CW'(DEPTH));

    unique case (state)
      IDLE: begin
        if (bus.halt) state_next = HALTED;
        else if (bus.redirect) begin
          fpc_next   = target;
          state_next = REQ;
        end else if (room) state_next = REQ;
      end
      REQ: begin
        if (bus.halt) state_next = ack ? HALTED : DRAIN_HALT;
        else if (bus.redirect) begin
          fpc_next   = target;
          state_next = ack ? REQ : DRAIN;
        end else if (ack) begin
          fpc_next   = fpc + 16'd2;
          state_next = room ? REQ : IDLE;
        end
      end
      DRAIN: begin
        if (bus.halt) state_next = ack ? HALTED : DRAIN_HALT;
        else begin
          if (bus.redirect) fpc_next = target;
          if (ack) state_next = REQ;
        end
      end
      DRAIN_HALT: begin
        if (ack) state_next = HALTED;
      end
      HALTED: state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      fpc    <= RESET_PC;
      addr_q <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      fpc   <= fpc_next;
      cnt   <= cnt_next;
      if (state == REQ) addr_q <= fpc;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.imem_data;
      fifo_pc[wr_ptr]   <= fpc;
    end
  end

  // a drain keeps presenting the address of the request still in flight
  assign bus.imem_req   = (state == REQ) || (state == DRAIN) || (state == DRAIN_HALT);
  assign bus.imem_addr  = ((state == DRAIN) || (state == DRAIN_HALT)) ? addr_q : fpc;
  assign bus.inst_valid = valid;
  assign bus.inst       = valid ? fifo_inst[rd_ptr] : 16'h0000;
  assign bus.inst_pc    = valid ? fifo_pc[rd_ptr]   : 16'h0000;
  assign bus.halted     = (state == HALTED);
  assign bus.count      = cnt;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed bench with latency-programmable memory and pop scoreboard.
module tb_instr_fetch_unit;
  localparam logic [15:0] KEY = 16'h5A5A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mem_lat = 4;
  int   mcnt = 0;
  int   last_pop_cyc = 0;
  int   c_req, c_valid, rises;
  logic found, prev_req, seen_req;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  instr_fetch_unit_if #(.DEPTH(4)) bus();

  instr_fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory: ack arrives mem_lat cycles after the request is first seen
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      bus.imem_ack = 1'b0;
      mcnt = 0;
    end else begin
      bus.imem_ack = 1'b0;
      if (bus.imem_req) begin
        if (mcnt >= mem_lat) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = bus.imem_addr ^ KEY;
          mcnt = 0;
        end else mcnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.inst_valid && bus.inst_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_pop: observed pc %h expected no entry", bus.inst_pc);
        end
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", bus.inst_pc, e);
        check("pop_inst", bus.inst, e ^ KEY);
        last_pop_cyc = cyc;
      end
    end
  end

  task automatic drain_queue(input string tag);
    logic done;
    done = 1'b0;
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    bus.inst_ready = 1'b0;
    check(tag, done, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_data = 16'h0000;
    bus.inst_ready = 1'b0;
    bus.redirect = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.halt = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_req", bus.imem_req, 1'b0);
    check("rst_addr", bus.imem_addr, 16'hFFFC);
    check("rst_valid", bus.inst_valid, 1'b0);
    check("rst_inst", bus.inst, 16'h0000);
    check("rst_inst_pc", bus.inst_pc, 16'h0000);
    check("rst_halted", bus.halted, 1'b0);
    check("rst_count", bus.count, 3'd0);

    // streaming with latency 4, PC wrap FFFC -> 0000
    for (int i = 0; i < 6; i++) exp_q.push_back(16'hFFFC + 16'(2 * i));
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("req_before_edge", bus.imem_req, 1'b0);
    @(negedge clk);
    check("req_after_edge", bus.imem_req, 1'b1);
    check("first_addr", bus.imem_addr, 16'hFFFC);
    c_req = cyc;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.inst_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    c_valid = cyc;
    check("first_valid_seen", found, 1'b1);
    check("first_valid_latency", c_valid - c_req, 5);
    drain_queue("stream_drain");
    check("stream_last_pop", last_pop_cyc - c_req, 30);

    // backpressure, latency 1: fills to 4, one pop -> one request
    mem_lat = 1;
    for (int i = 0; i < 5; i++) exp_q.push_back(16'h0008 + 16'(2 * i));
    repeat (40) @(negedge clk);
    check("full_count", bus.count, 3'd4);
    check("full_req", bus.imem_req, 1'b0);
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.inst_ready = 1'b0;
    prev_req = 1'b0;
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req && !prev_req) rises++;
      prev_req = bus.imem_req;
    end
    check("refill_requests", rises, 1);
    check("refill_count", bus.count, 3'd4);
    mem_lat = 4;
    drain_queue("full_drain");

    // redirect mid-request to 0041: flush, stale ack dropped, refetch at 0040
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_req && !bus.imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("redir_wait", found, 1'b1);
    exp_q.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0040 + 16'(2 * i));
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0041;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    @(negedge clk);
    check("redir_count", bus.count, 3'd0);
    check("redir_valid", bus.inst_valid, 1'b0);
    check("drain_req", bus.imem_req, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_ack) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("stale_ack_seen", found, 1'b1);
    @(negedge clk);
    check("redir_addr", bus.imem_addr, 16'h0040);
    check("redir_addr_req", bus.imem_req, 1'b1);
    drain_queue("redir_drain");

    // redirect on the ack cycle: returned word dropped, 0100 next
    mem_lat = 3;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("ack_redir_wait", found, 1'b1);
    exp_q.delete();
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0102);
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0100;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    @(negedge clk);
    check("ack_redir_addr", bus.imem_addr, 16'h0100);
    check("ack_redir_req", bus.imem_req, 1'b1);
    check("ack_redir_count", bus.count, 3'd0);
    drain_queue("ack_redir_drain");

    // halt with redirect while a request is outstanding
    mem_lat = 5;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.imem_req && !bus.imem_ack) begin
        found = 1'b1;
        break;
      end
    end
    check("halt_wait", found, 1'b1);
    exp_q.delete();
    bus.halt = 1'b1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0200;
    @(posedge clk);
    #1;
    bus.halt = 1'b0;
    bus.redirect = 1'b0;
    bus.inst_ready = 1'b1;
    @(negedge clk);
    check("halt_valid", bus.inst_valid, 1'b0);
    check("halt_count", bus.count, 3'd0);
    check("halt_not_yet", bus.halted, 1'b0);
    check("halt_drain_req", bus.imem_req, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.halted) begin
        found = 1'b1;
        break;
      end
    end
    check("halted_reached", found, 1'b1);
    @(posedge clk);
    #1;
    bus.redirect = 1'b1;
    bus.redirect_pc = 16'h0300;
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    seen_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req) seen_req = 1'b1;
    end
    check("halted_no_req", seen_req, 1'b0);
    check("halted_sticky", bus.halted, 1'b1);
    check("halted_valid", bus.inst_valid, 1'b0);
    bus.inst_ready = 1'b0;

    // reset recovery, then asynchronous reset in the middle of a request
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_lat = 8;
    exp_q.delete();
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.imem_req) begin
        found = 1'b1;
        break;
      end
    end
    check("rerun_req", found, 1'b1);
    check("rerun_halted", bus.halted, 1'b0);
    repeat (3) @(negedge clk);
    check("mid_req", bus.imem_req, 1'b1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_req", bus.imem_req, 1'b0);
    check("async_addr", bus.imem_addr, 16'hFFFC);
    check("async_count", bus.count, 3'd0);
    check("async_valid", bus.inst_valid, 1'b0);
    check("async_halted", bus.halted, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
